// File: rtl/id_issue_ctrl.sv
// id_issue_ctrl: decode/issue control for the ID/EX pipeline register.
// Decodes the IF/ID opcode with zero latency, stalls on load-use hazards
// using a shift-register scoreboard of in-flight loads, and squashes
// wrong-path instructions for FLUSH_CYCLES cycles after a redirect.
// Optional feature macro: ISSUE_STATS_EN (adds saturating stall/flush counters).
module id_issue_ctrl #(
    parameter int LOAD_HAZ_DEPTH = 2,
    parameter int FLUSH_CYCLES   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [3:0]  in_opcode,
    input  logic [5:0]  in_rs,
    input  logic [5:0]  in_rt,
    input  logic [5:0]  in_rd,
    input  logic        redirect,
    output logic        out_ctrl_regwrt,
    output logic        out_ctrl_memtoreg,
    output logic        out_ctrl_branch,
    output logic        out_ctrl_btype,
    output logic        out_ctrl_jump,
    output logic        out_ctrl_memrd,
    output logic        out_ctrl_memwrt,
    output logic [2:0]  out_ctrl_aluop,
    output logic        out_ctrl_alusrc1,
    output logic        out_ctrl_alusrc0,
    output logic [5:0]  out_rd,
    output logic        stall_if,
`ifdef ISSUE_STATS_EN
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt,
`endif
    output logic        bubble
);

    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_NEG  = 4'b0011;
    localparam logic [3:0] OP_INC  = 4'b0100;
    localparam logic [3:0] OP_LD   = 4'b0101;
    localparam logic [3:0] OP_ST   = 4'b0110;
    localparam logic [3:0] OP_BRZ  = 4'b0111;
    localparam logic [3:0] OP_BRN  = 4'b1000;
    localparam logic [3:0] OP_J    = 4'b1001;
    localparam logic [3:0] OP_SVPC = 4'b1010;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_FLUSH = 2'd1
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;

    logic [LOAD_HAZ_DEPTH-1:0] sb_valid_q, sb_valid_d;
    logic [5:0]                sb_rd_q [LOAD_HAZ_DEPTH];
    logic [5:0]                sb_rd_d [LOAD_HAZ_DEPTH];

    // decoded fields for the instruction currently in IF/ID
    logic       dec_known_s;
    logic       dec_reads_rs_s;
    logic       dec_reads_rt_s;
    logic       dec_regwrt_s;
    logic       dec_memtoreg_s;
    logic       dec_branch_s;
    logic       dec_btype_s;
    logic       dec_jump_s;
    logic       dec_memrd_s;
    logic       dec_memwrt_s;
    logic [2:0] dec_aluop_s;
    logic       dec_alusrc1_s;
    logic       dec_alusrc0_s;

    logic       hazard_s;
    logic       issue_s;
    logic       ld_issue_s;
    logic       stall_s;
    logic       bubble_s;
    logic       stall_evt_s;
    logic       flush_evt_s;

    // opcode decode table; unknown opcodes decode to an all-zero NOP
    always_comb begin
        dec_known_s    = 1'b1;
        dec_reads_rs_s = 1'b0;
        dec_reads_rt_s = 1'b0;
        dec_regwrt_s   = 1'b0;
        dec_memtoreg_s = 1'b0;
        dec_branch_s   = 1'b0;
        dec_btype_s    = 1'b0;
        dec_jump_s     = 1'b0;
        dec_memrd_s    = 1'b0;
        dec_memwrt_s   = 1'b0;
        dec_aluop_s    = 3'b000;
        dec_alusrc1_s  = 1'b0;
        dec_alusrc0_s  = 1'b0;
        case (in_opcode)
            OP_ADD: begin
                dec_regwrt_s = 1'b1; dec_aluop_s = 3'b010;
                dec_reads_rs_s = 1'b1; dec_reads_rt_s = 1'b1;
            end
            OP_SUB: begin
                dec_regwrt_s = 1'b1; dec_aluop_s = 3'b011;
                dec_reads_rs_s = 1'b1; dec_reads_rt_s = 1'b1;
            end
            OP_NEG: begin
                dec_regwrt_s = 1'b1; dec_aluop_s = 3'b001;
                dec_reads_rs_s = 1'b1;
            end
            OP_INC: begin
                dec_regwrt_s = 1'b1; dec_aluop_s = 3'b010; dec_alusrc0_s = 1'b1;
                dec_reads_rs_s = 1'b1;
            end
            OP_LD: begin
                dec_regwrt_s = 1'b1; dec_memrd_s = 1'b1; dec_memtoreg_s = 1'b1;
                dec_reads_rs_s = 1'b1;
            end
            OP_ST: begin
                dec_memwrt_s = 1'b1;
                dec_reads_rs_s = 1'b1; dec_reads_rt_s = 1'b1;
            end
            OP_BRZ: begin
                dec_branch_s = 1'b1; dec_btype_s = 1'b0;
                dec_reads_rs_s = 1'b1;
            end
            OP_BRN: begin
                dec_branch_s = 1'b1; dec_btype_s = 1'b1;
                dec_reads_rs_s = 1'b1;
            end
            OP_J: begin
                dec_jump_s = 1'b1;
                dec_reads_rs_s = 1'b1;
            end
            OP_SVPC: begin
                dec_regwrt_s = 1'b1; dec_alusrc1_s = 1'b1; dec_alusrc0_s = 1'b1;
                dec_aluop_s = 3'b010;
            end
            default: begin
                dec_known_s = 1'b0;
            end
        endcase
    end

    // load-use hazard: any in-flight load whose rd is a source actually read
    always_comb begin
        hazard_s = 1'b0;
        for (int i = 0; i < LOAD_HAZ_DEPTH; i++) begin
            if (sb_valid_q[i] &&
                ((dec_reads_rs_s && (sb_rd_q[i] == in_rs)) ||
                 (dec_reads_rt_s && (sb_rd_q[i] == in_rt)))) begin
                hazard_s = 1'b1;
            end else begin
                hazard_s = hazard_s;
            end
        end
        hazard_s = hazard_s & in_valid;
    end

    // ISSUE/FLUSH next-state and issue/stall/bubble decisions; redirect beats hazard
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        issue_s     = 1'b0;
        stall_s     = 1'b0;
        bubble_s    = 1'b0;
        stall_evt_s = 1'b0;
        flush_evt_s = 1'b0;
        case (state_q)
            ST_ISSUE: begin
                if (redirect) begin
                    bubble_s    = 1'b1;
                    flush_evt_s = 1'b1;
                    if (FLUSH_CYCLES != 0) begin
                        state_d = ST_FLUSH;
                        cnt_d   = FLUSH_LOAD;
                    end else begin
                        state_d = ST_ISSUE;
                        cnt_d   = 3'd0;
                    end
                end else if (hazard_s) begin
                    bubble_s    = 1'b1;
                    stall_s     = 1'b1;
                    stall_evt_s = 1'b1;
                end else begin
                    issue_s  = in_valid;
                    bubble_s = ~in_valid;
                end
            end
            ST_FLUSH: begin
                bubble_s    = 1'b1;
                flush_evt_s = 1'b1;
                if (redirect) begin
                    cnt_d = FLUSH_LOAD;
                end else if (cnt_q <= 3'd1) begin
                    state_d = ST_ISSUE;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d  = ST_ISSUE;
                cnt_d    = 3'd0;
                bubble_s = 1'b1;
            end
        endcase
    end

    assign ld_issue_s = issue_s && (in_opcode == OP_LD);

    // scoreboard shift: slot 0 captures a newly issued load, older slots age out
    always_comb begin
        sb_valid_d[0] = ld_issue_s;
        sb_rd_d[0]    = ld_issue_s ? in_rd : 6'd0;
        for (int i = 1; i < LOAD_HAZ_DEPTH; i++) begin
            sb_valid_d[i] = sb_valid_q[i-1];
            sb_rd_d[i]    = sb_rd_q[i-1];
        end
    end

    // state, flush counter and scoreboard registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ISSUE;
            cnt_q      <= 3'd0;
            sb_valid_q <= '0;
            for (int i = 0; i < LOAD_HAZ_DEPTH; i++) begin
                sb_rd_q[i] <= 6'd0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sb_valid_q <= sb_valid_d;
            for (int i = 0; i < LOAD_HAZ_DEPTH; i++) begin
                sb_rd_q[i] <= sb_rd_d[i];
            end
        end
    end

    // output drive: decoded control only on a real issue, everything 0 in reset
    always_comb begin
        out_ctrl_regwrt   = 1'b0;
        out_ctrl_memtoreg = 1'b0;
        out_ctrl_branch   = 1'b0;
        out_ctrl_btype    = 1'b0;
        out_ctrl_jump     = 1'b0;
        out_ctrl_memrd    = 1'b0;
        out_ctrl_memwrt   = 1'b0;
        out_ctrl_aluop    = 3'b000;
        out_ctrl_alusrc1  = 1'b0;
        out_ctrl_alusrc0  = 1'b0;
        out_rd            = 6'd0;
        stall_if          = rst_n & stall_s;
        bubble            = rst_n & bubble_s;
        if (rst_n && issue_s) begin
            out_ctrl_regwrt   = dec_regwrt_s;
            out_ctrl_memtoreg = dec_memtoreg_s;
            out_ctrl_branch   = dec_branch_s;
            out_ctrl_btype    = dec_btype_s;
            out_ctrl_jump     = dec_jump_s;
            out_ctrl_memrd    = dec_memrd_s;
            out_ctrl_memwrt   = dec_memwrt_s;
            out_ctrl_aluop    = dec_aluop_s;
            out_ctrl_alusrc1  = dec_alusrc1_s;
            out_ctrl_alusrc0  = dec_alusrc0_s;
            out_rd            = dec_known_s ? in_rd : 6'd0;
        end else begin
            out_rd = 6'd0;
        end
    end

`ifdef ISSUE_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    // saturating event counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_evt_s && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (flush_evt_s && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    logic unused_evt_s;
    assign unused_evt_s = stall_evt_s ^ flush_evt_s;
`endif

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Directed testbench for id_issue_ctrl (LOAD_HAZ_DEPTH=2, FLUSH_CYCLES=2).
// Inputs change 1ns after the rising edge; outputs are checked on the falling edge.
module tb_id_issue_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [3:0]  in_opcode;
    logic [5:0]  in_rs, in_rt, in_rd;
    logic        redirect;
    logic        out_ctrl_regwrt, out_ctrl_memtoreg, out_ctrl_branch, out_ctrl_btype;
    logic        out_ctrl_jump, out_ctrl_memrd, out_ctrl_memwrt;
    logic [2:0]  out_ctrl_aluop;
    logic        out_ctrl_alusrc1, out_ctrl_alusrc0;
    logic [5:0]  out_rd;
    logic        stall_if, bubble;
`ifdef ISSUE_STATS_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif

    int n_total = 0;
    int n_bad   = 0;

    id_issue_ctrl #(.LOAD_HAZ_DEPTH(2), .FLUSH_CYCLES(2)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_valid          (in_valid),
        .in_opcode         (in_opcode),
        .in_rs             (in_rs),
        .in_rt             (in_rt),
        .in_rd             (in_rd),
        .redirect          (redirect),
        .out_ctrl_regwrt   (out_ctrl_regwrt),
        .out_ctrl_memtoreg (out_ctrl_memtoreg),
        .out_ctrl_branch   (out_ctrl_branch),
        .out_ctrl_btype    (out_ctrl_btype),
        .out_ctrl_jump     (out_ctrl_jump),
        .out_ctrl_memrd    (out_ctrl_memrd),
        .out_ctrl_memwrt   (out_ctrl_memwrt),
        .out_ctrl_aluop    (out_ctrl_aluop),
        .out_ctrl_alusrc1  (out_ctrl_alusrc1),
        .out_ctrl_alusrc0  (out_ctrl_alusrc0),
        .out_rd            (out_rd),
        .stall_if          (stall_if),
`ifdef ISSUE_STATS_EN
        .stall_cnt         (stall_cnt),
        .flush_cnt         (flush_cnt),
`endif
        .bubble            (bubble)
    );

    // 10ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // packed control: {regwrt,memtoreg,branch,btype,jump,memrd,memwrt,aluop[2:0],alusrc1,alusrc0}
    logic [11:0] ctrl_vec;
    assign ctrl_vec = {out_ctrl_regwrt, out_ctrl_memtoreg, out_ctrl_branch, out_ctrl_btype,
                       out_ctrl_jump, out_ctrl_memrd, out_ctrl_memwrt, out_ctrl_aluop,
                       out_ctrl_alusrc1, out_ctrl_alusrc0};

    localparam logic [11:0] C_NONE = 12'h000;
    localparam logic [11:0] C_ADD  = 12'h808; // regwrt, aluop=010
    localparam logic [11:0] C_SUB  = 12'h80C; // regwrt, aluop=011
    localparam logic [11:0] C_NEG  = 12'h804; // regwrt, aluop=001
    localparam logic [11:0] C_INC  = 12'h809; // regwrt, aluop=010, alusrc0
    localparam logic [11:0] C_LD   = 12'hC40; // regwrt, memtoreg, memrd
    localparam logic [11:0] C_ST   = 12'h020; // memwrt
    localparam logic [11:0] C_BRZ  = 12'h200; // branch
    localparam logic [11:0] C_BRN  = 12'h300; // branch, btype
    localparam logic [11:0] C_J    = 12'h080; // jump
    localparam logic [11:0] C_SVPC = 12'h80B; // regwrt, aluop=010, alusrc1, alusrc0

    logic [11:0] exp_tab [16];
    initial begin
        exp_tab[0]  = C_NONE; exp_tab[1]  = C_ADD; exp_tab[2]  = C_SUB; exp_tab[3] = C_NEG;
        exp_tab[4]  = C_INC;  exp_tab[5]  = C_LD;  exp_tab[6]  = C_ST;  exp_tab[7] = C_BRZ;
        exp_tab[8]  = C_BRN;  exp_tab[9]  = C_J;   exp_tab[10] = C_SVPC;
        exp_tab[11] = C_NONE; exp_tab[12] = C_NONE; exp_tab[13] = C_NONE;
        exp_tab[14] = C_NONE; exp_tab[15] = C_NONE;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [11:0] e_ctrl, input logic [5:0] e_rd,
                             input logic e_stall, input logic e_bubble);
        @(negedge clk);
        check_eq({tag, ".ctrl"},   32'(ctrl_vec), 32'(e_ctrl));
        check_eq({tag, ".rd"},     32'(out_rd),   32'(e_rd));
        check_eq({tag, ".stall"},  32'(stall_if), 32'(e_stall));
        check_eq({tag, ".bubble"}, 32'(bubble),   32'(e_bubble));
    endtask

    task automatic drv(input logic v, input logic [3:0] op, input logic [5:0] rs,
                       input logic [5:0] rt, input logic [5:0] rd, input logic rdr);
        in_valid  = v;
        in_opcode = op;
        in_rs     = rs;
        in_rt     = rt;
        in_rd     = rd;
        redirect  = rdr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1) reset with a valid ADD presented
        rst_n = 1'b0;
        drv(1'b1, 4'b0001, 6'd1, 6'd2, 6'd5, 1'b0);
        tick(); tick();
        check_out("rst", C_NONE, 6'd0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        check_out("rst_rel_add", C_ADD, 6'd5, 1'b0, 1'b0);
        tick();

        // 2) decode sweep, rd=5, sources r10 never match the swept rd
        for (int op = 0; op < 16; op++) begin
            drv(1'b1, 4'(op), 6'd10, 6'd10, 6'd5, 1'b0);
            check_out($sformatf("dec%0d", op), exp_tab[op],
                      ((op >= 1) && (op <= 10)) ? 6'd5 : 6'd0, 1'b0, 1'b0);
            tick();
        end
        drv(1'b0, 4'b0000, 6'd0, 6'd0, 6'd0, 1'b0);
        check_out("idle", C_NONE, 6'd0, 1'b0, 1'b1);
        tick(); tick(); tick();

        // 3) load-use: LD r3 then ADD r4=r3+r1 -> two stall cycles
        drv(1'b1, 4'b0101, 6'd1, 6'd0, 6'd3, 1'b0);
        check_out("lu_ld", C_LD, 6'd3, 1'b0, 1'b0);
        tick();
        drv(1'b1, 4'b0001, 6'd3, 6'd1, 6'd4, 1'b0);
        check_out("lu_stall1", C_NONE, 6'd0, 1'b1, 1'b1);
        tick();
        check_out("lu_stall2", C_NONE, 6'd0, 1'b1, 1'b1);
        tick();
        check_out("lu_issue", C_ADD, 6'd4, 1'b0, 1'b0);
`ifdef ISSUE_STATS_EN
        check_eq("stat_stall", 32'(stall_cnt), 32'd2);
`endif
        tick();
        // independent ADD after LD: no stall
        drv(1'b1, 4'b0101, 6'd1, 6'd0, 6'd3, 1'b0);
        tick();
        drv(1'b1, 4'b0001, 6'd1, 6'd2, 6'd4, 1'b0);
        check_out("indep", C_ADD, 6'd4, 1'b0, 1'b0);
        tick();
        // rt-only dependence one slot deep (LD then one unrelated, then SUB reads rt=r7)
        drv(1'b1, 4'b0101, 6'd1, 6'd0, 6'd7, 1'b0);
        tick();
        drv(1'b1, 4'b0011, 6'd2, 6'd0, 6'd8, 1'b0);
        tick();
        drv(1'b1, 4'b0010, 6'd1, 6'd7, 6'd9, 1'b0);
        check_out("rt_stall", C_NONE, 6'd0, 1'b1, 1'b1);
        tick();
        check_out("rt_issue", C_SUB, 6'd9, 1'b0, 1'b0);
        tick();
        drv(1'b0, 4'b0000, 6'd0, 6'd0, 6'd0, 1'b0);
        tick(); tick(); tick();

        // 4) redirect two cycles after BRZ
`ifdef ISSUE_STATS_EN
        // the rt test above added one stall cycle
        check_eq("stat_stall3", 32'(stall_cnt), 32'd3);
`endif
        drv(1'b1, 4'b0111, 6'd1, 6'd0, 6'd0, 1'b0);
        check_out("br_brz", C_BRZ, 6'd0, 1'b0, 1'b0);
        tick();
        drv(1'b1, 4'b0001, 6'd1, 6'd2, 6'd6, 1'b0);
        tick();
        drv(1'b1, 4'b0001, 6'd1, 6'd2, 6'd6, 1'b1);
        check_out("rd_cyc0", C_NONE, 6'd0, 1'b0, 1'b1);
        tick();
        redirect = 1'b0;
        check_out("rd_cyc1", C_NONE, 6'd0, 1'b0, 1'b1);
        tick();
        check_out("rd_cyc2", C_NONE, 6'd0, 1'b0, 1'b1);
        tick();
        check_out("rd_after", C_ADD, 6'd6, 1'b0, 1'b0);
`ifdef ISSUE_STATS_EN
        check_eq("stat_flush", 32'(flush_cnt), 32'd3);
`endif
        tick();

        // 5) hazard and redirect together, then redirect again inside FLUSH
        drv(1'b1, 4'b0101, 6'd1, 6'd0, 6'd3, 1'b0);
        tick();
        drv(1'b1, 4'b0001, 6'd3, 6'd1, 6'd4, 1'b1);
        check_out("sim_cyc0", C_NONE, 6'd0, 1'b0, 1'b1);
        tick();
        redirect = 1'b0;
        check_out("sim_fl1", C_NONE, 6'd0, 1'b0, 1'b1);
        tick();
        redirect = 1'b1;
        check_out("sim_fl2_rdr", C_NONE, 6'd0, 1'b0, 1'b1);
        tick();
        redirect = 1'b0;
        check_out("sim_reload1", C_NONE, 6'd0, 1'b0, 1'b1);
        tick();
        check_out("sim_reload2", C_NONE, 6'd0, 1'b0, 1'b1);
        tick();
        check_out("sim_issue", C_ADD, 6'd4, 1'b0, 1'b0);
        tick();

        // 6) async reset mid-FLUSH, then first cycle after release decodes normally
        drv(1'b1, 4'b0100, 6'd1, 6'd0, 6'd2, 1'b1);
        tick();
        redirect = 1'b0;
        check_out("mf_flush", C_NONE, 6'd0, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mf_rst_bubble", 32'(bubble), 32'd0);
        check_eq("mf_rst_ctrl", 32'(ctrl_vec), 32'd0);
`ifdef ISSUE_STATS_EN
        check_eq("mf_rst_scnt", 32'(stall_cnt), 32'd0);
        check_eq("mf_rst_fcnt", 32'(flush_cnt), 32'd0);
`endif
        tick();
        rst_n = 1'b1;
        check_out("mf_release", C_INC, 6'd2, 1'b0, 1'b0);
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
